nand_cmd_engine: RTL and testbench

//  Executes one NAND flash operation described by a command record held in an

---
 rtl/nand_cmd_engine.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_nand_cmd_engine.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/nand_cmd_engine.sv
// nand_cmd_engine: fetches a command record from an embedded 4K x 8 RAM and
// executes one NAND flash operation (read, program, erase, read ID) on an
// asynchronous 8-bit NAND bus. The host loads records and reads results
// through the shared RAM port, with host reads captured in a byte latch.
module nand_cmd_engine #(
    parameter int ADDR_W     = 12,
    parameter int DEPTH      = 4096,
    parameter int T_PULSE    = 2,
    parameter int T_HOLD     = 2,
    parameter int T_WB       = 4,
    parameter int RB_TIMEOUT = 2**20,
    parameter int MAX_LEN    = 2112
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [7:0]        host_wdata,
    input  logic              host_we,
    input  logic              host_re,
    input  logic              host_rd_clr,
    output logic [7:0]        host_rdata,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [7:0]        status,
    output logic              ce_n,
    output logic              cle,
    output logic              ale,
    output logic              we_n,
    output logic              re_n,
    input  logic              rb,
    input  logic [7:0]        io_in,
    output logic [7:0]        io_write,
    output logic              io_drive_en
);

    localparam int CYC  = T_PULSE + T_HOLD;
    localparam int PH_W = $clog2(CYC + 2);
    localparam int WT_W = $clog2(RB_TIMEOUT + 1);
    localparam logic [PH_W-1:0]   PH_LAST    = PH_W'(CYC - 1);
    localparam logic [PH_W-1:0]   PULSE_N    = PH_W'(T_PULSE);
    localparam logic [PH_W-1:0]   PULSE_LAST = PH_W'(T_PULSE - 1);
    localparam logic [WT_W-1:0]   WB_LAST    = WT_W'(T_WB - 1);
    localparam logic [WT_W-1:0]   RB_LAST    = WT_W'(RB_TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] PAYLOAD    = ADDR_W'(8);

    localparam logic [7:0] OP_READ  = 8'h52;
    localparam logic [7:0] OP_PROG  = 8'h57;
    localparam logic [7:0] OP_ERASE = 8'h45;
    localparam logic [7:0] OP_ID    = 8'h49;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_CMD1, S_ADDR, S_DOUT, S_CMD2,
        S_WAIT_WB, S_WAIT_RB, S_DIN, S_STAT_CMD, S_STAT_IN, S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [PH_W-1:0]   ph_q, ph_d;        // phase within the current bus cycle
    logic [ADDR_W-1:0] idx_q, idx_d;      // fetch index, then payload byte index
    logic [ADDR_W-1:0] len_q, len_d;
    logic [2:0]        ai_q, ai_d;        // record index of the next address byte
    logic [WT_W-1:0]   wt_q, wt_d;        // tWB and ready-timeout counter
    logic [7:0]        status_q, status_d;
    logic              rb_s1_q, rb_s2_q;
    logic [7:0]        rec_q [8];
    logic              rec_we;

    logic [7:0]        mem [DEPTH];
    logic [7:0]        ram_q;
    logic              ram_we, c_we;
    logic [ADDR_W-1:0] ram_addr, c_addr;
    logic [7:0]        ram_wdata;

    logic              rd_pend_q;
    logic [7:0]        hold_q;

    logic [7:0]        op;
    logic [15:0]       raw_len;
    logic [PH_W-1:0]   rel;
    logic              in_dout, is_wr, is_rd, in_bus, cyc_end, rd_sample;
    logic [7:0]        cmd1_byte, cmd2_byte, addr_byte;

    assign op      = rec_q[0];
    assign raw_len = {rec_q[6], rec_q[7]};
    assign busy    = (state_q != S_IDLE);
    assign done    = (state_q == S_DONE);
    assign status  = status_q;

    // Bus-cycle timing: phase decode, pin levels and the byte driven on io.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch.
        in_dout   = (state_q == S_DOUT);
        // DOUT spends phase 0 fetching the payload byte before the strobe.
        rel       = in_dout ? ph_q - PH_W'(1) : ph_q;
        is_wr     = (state_q inside {S_CMD1, S_ADDR, S_CMD2, S_STAT_CMD}) ||
                    (in_dout && ph_q != '0);
        is_rd     = (state_q inside {S_DIN, S_STAT_IN});
        in_bus    = is_wr || is_rd || in_dout;
        cyc_end   = (is_wr || is_rd) && (rel == PH_LAST);
        rd_sample = is_rd && (rel == PULSE_LAST);

        case (op)
            OP_READ:  cmd1_byte = 8'h00;
            OP_PROG:  cmd1_byte = 8'h80;
            OP_ERASE: cmd1_byte = 8'h60;
            default:  cmd1_byte = 8'h90;
        endcase
        case (op)
            OP_READ: cmd2_byte = 8'h30;
            OP_PROG: cmd2_byte = 8'h10;
            default: cmd2_byte = 8'hD0;
        endcase
        addr_byte = (op == OP_ID) ? 8'h00 : rec_q[ai_q];

        ce_n        = !(state_q inside {S_CMD1, S_ADDR, S_DOUT, S_CMD2, S_WAIT_WB,
                                        S_WAIT_RB, S_DIN, S_STAT_CMD, S_STAT_IN});
        // Latch enables drop in the final hold phase so they never run across cycles.
        cle         = (state_q inside {S_CMD1, S_CMD2, S_STAT_CMD}) && (rel != PH_LAST);
        ale         = (state_q == S_ADDR) && (rel != PH_LAST);
        we_n        = !(is_wr && rel < PULSE_N);
        re_n        = !(is_rd && rel < PULSE_N);
        io_drive_en = is_wr;
        io_write    = 8'h00;
        if (is_wr) begin
            case (state_q)
                S_CMD1:  io_write = cmd1_byte;
                S_ADDR:  io_write = addr_byte;
                S_DOUT:  io_write = ram_q;
                S_CMD2:  io_write = cmd2_byte;
                default: io_write = 8'h70;
            endcase
        end
    end

    // Sequencer next state: record fetch, per-opcode bus sequence, ready wait.
    always_comb begin
        state_d  = state_q;
        ph_d     = ph_q;
        idx_d    = idx_q;
        len_d    = len_q;
        ai_d     = ai_q;
        wt_d     = wt_q;
        status_d = status_q;
        c_we     = 1'b0;
        c_addr   = PAYLOAD + idx_q;
        rec_we   = 1'b0;
        if (in_bus) ph_d = cyc_end ? '0 : ph_q + PH_W'(1);

        case (state_q)
            S_IDLE: if (start) begin
                state_d  = S_FETCH;
                idx_d    = '0;
                ph_d     = '0;
                status_d = 8'h00;
            end
            S_FETCH: begin
                c_addr = idx_q;
                rec_we = (idx_q != '0);
                if (idx_q == ADDR_W'(8)) state_d = S_DECODE;
                else                     idx_d   = idx_q + ADDR_W'(1);
            end
            S_DECODE: begin
                len_d = (raw_len > 16'(MAX_LEN)) ? ADDR_W'(MAX_LEN) : raw_len[ADDR_W-1:0];
                idx_d = '0;
                ph_d  = '0;
                ai_d  = (op == OP_ERASE) ? 3'd3 : 3'd1;
                if (op inside {OP_READ, OP_PROG, OP_ERASE, OP_ID}) begin
                    state_d = S_CMD1;
                end else begin
                    state_d  = S_DONE;
                    status_d = 8'hFF;
                end
            end
            S_CMD1: if (cyc_end) state_d = S_ADDR;
            S_ADDR: if (cyc_end) begin
                if (op == OP_ID)         state_d = (len_q == '0) ? S_DONE : S_DIN;
                else if (ai_q != 3'd5)   ai_d    = ai_q + 3'd1;
                else if (op == OP_PROG)  state_d = (len_q == '0) ? S_CMD2 : S_DOUT;
                else                     state_d = S_CMD2;
            end
            S_DOUT: if (cyc_end) begin
                if (idx_q == len_q - ADDR_W'(1)) state_d = S_CMD2;
                else                             idx_d   = idx_q + ADDR_W'(1);
            end
            S_CMD2: if (cyc_end) begin
                state_d = S_WAIT_WB;
                wt_d    = '0;
            end
            S_WAIT_WB: begin
                wt_d = wt_q + WT_W'(1);
                if (wt_q == WB_LAST) begin
                    state_d = S_WAIT_RB;
                    wt_d    = '0;
                end
            end
            S_WAIT_RB: begin
                wt_d = wt_q + WT_W'(1);
                if (rb_s2_q) begin
                    if (op == OP_READ) state_d = (len_q == '0) ? S_DONE : S_DIN;
                    else               state_d = S_STAT_CMD;
                end else if (wt_q == RB_LAST) begin
                    state_d  = S_DONE;
                    status_d = 8'hFE;
                end
            end
            S_DIN: begin
                c_we = rd_sample;
                if (cyc_end) begin
                    if (idx_q == len_q - ADDR_W'(1)) state_d = S_DONE;
                    else                             idx_d   = idx_q + ADDR_W'(1);
                end
            end
            S_STAT_CMD: if (cyc_end) state_d = S_STAT_IN;
            S_STAT_IN: begin
                if (rd_sample) status_d = io_in;
                if (cyc_end)   state_d  = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Sequencer registers and the two-flop rb synchroniser.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state uses non-blocking assignment so every flop sees pre-edge values.
        if (rst) begin
            state_q  <= S_IDLE;
            ph_q     <= '0;
            idx_q    <= '0;
            len_q    <= '0;
            ai_q     <= '0;
            wt_q     <= '0;
            status_q <= '0;
            rb_s1_q  <= 1'b0;
            rb_s2_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            ph_q     <= ph_d;
            idx_q    <= idx_d;
            len_q    <= len_d;
            ai_q     <= ai_d;
            wt_q     <= wt_d;
            status_q <= status_d;
            rb_s1_q  <= rb;
            rb_s2_q  <= rb_s1_q;
        end
    end

    // Record header capture; RAM data lags the fetch address by one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) rec_q[i] <= '0;
        end else if (rec_we) begin
            rec_q[idx_q[2:0] - 3'd1] <= ram_q;
        end
    end

    // The controller owns the RAM port for the whole operation.
    assign ram_we    = busy ? c_we   : host_we;
    assign ram_addr  = busy ? c_addr : host_addr;
    assign ram_wdata = busy ? io_in  : host_wdata;

    // Single-port RAM, one-cycle read latency, write-first.
    always_ff @(posedge clk) begin
        // NOTE: RAM array and read register have no reset so they map onto block RAM.
        if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
            ram_q         <= ram_wdata;
        end else begin
            ram_q <= mem[ram_addr];
        end
    end

    // Host read latch: clear wins, a pending read shows RAM data, else hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_pend_q <= 1'b0;
            hold_q    <= '0;
        end else begin
            rd_pend_q <= host_re && !host_rd_clr && !busy;
            if (host_rd_clr)    hold_q <= '0;
            else if (rd_pend_q) hold_q <= ram_q;
        end
    end

    assign host_rdata = rd_pend_q ? ram_q : hold_q;

endmodule

// File: tb/tb_nand_cmd_engine.sv
// tb_nand_cmd_engine: directed bench for nand_cmd_engine with a small NAND
// bus model that logs write cycles and returns queued bytes on read cycles.
module tb_nand_cmd_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] host_addr = '0;
    logic [7:0]  host_wdata = '0;
    logic        host_we = 1'b0, host_re = 1'b0, host_rd_clr = 1'b0;
    logic [7:0]  host_rdata;
    logic        start = 1'b0;
    logic        busy, done;
    logic [7:0]  status;
    logic        ce_n, cle, ale, we_n, re_n;
    logic        rb = 1'b1;
    logic [7:0]  io_in = 8'h00;
    logic [7:0]  io_write;
    logic        io_drive_en;

    int checks = 0;
    int errors = 0;

    nand_cmd_engine #(.RB_TIMEOUT(64)) dut (
        .clk(clk), .rst(rst),
        .host_addr(host_addr), .host_wdata(host_wdata), .host_we(host_we),
        .host_re(host_re), .host_rd_clr(host_rd_clr), .host_rdata(host_rdata),
        .start(start), .busy(busy), .done(done), .status(status),
        .ce_n(ce_n), .cle(cle), .ale(ale), .we_n(we_n), .re_n(re_n),
        .rb(rb), .io_in(io_in), .io_write(io_write), .io_drive_en(io_drive_en)
    );

    always #5 clk = ~clk;

    // NAND model: log each write cycle as {drive_en, cle, ale, byte}; serve reads.
    logic [10:0] bus_log [$];
    logic [7:0]  rd_data [16];
    logic [10:0] exp_log [$];
    int we_falls = 0, re_falls = 0, re_falls_rb0 = 0, ce_low = 0, done_cnt = 0;
    logic prev_we_n = 1'b1, prev_re_n = 1'b1;

    always @(negedge clk) begin
        if (!rst) begin
            if (!we_n && prev_we_n) begin
                we_falls++;
                bus_log.push_back({io_drive_en, cle, ale, io_write});
            end
            if (!re_n && prev_re_n) begin
                if (!rb) re_falls_rb0++;
                io_in = rd_data[re_falls % 16];
                re_falls++;
            end
            if (!ce_n) ce_low++;
            if (done)  done_cnt++;
        end
        prev_we_n = we_n;
        prev_re_n = re_n;
    end

    function automatic logic [10:0] cmd_e(input logic [7:0] b);
        return {3'b110, b};
    endfunction
    function automatic logic [10:0] adr_e(input logic [7:0] b);
        return {3'b101, b};
    endfunction
    function automatic logic [10:0] dat_e(input logic [7:0] b);
        return {3'b100, b};
    endfunction
    function automatic logic [7:0] pins();
        return {ce_n, cle, ale, we_n, re_n, io_drive_en, busy, done};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic host_write(input logic [11:0] a, input logic [7:0] d);
        @(negedge clk);
        host_addr = a; host_wdata = d; host_we = 1'b1;
        @(negedge clk);
        host_we = 1'b0;
    endtask

    task automatic host_read(input logic [11:0] a, output logic [7:0] d);
        @(negedge clk);
        host_addr = a; host_re = 1'b1;
        @(negedge clk);
        host_re = 1'b0;
        d = host_rdata;
    endtask

    task automatic load_rec(input logic [7:0] op, input logic [39:0] adr, input logic [15:0] len);
        host_write(12'h000, op);
        for (int i = 0; i < 5; i++) host_write(12'(1 + i), adr[39 - 8*i -: 8]);
        host_write(12'h006, len[15:8]);
        host_write(12'h007, len[7:0]);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int bound);
        bit seen = 1'b0;
        for (int n = 0; n < bound && !seen; n++) begin
            @(negedge clk);
            seen = done;
        end
        check({tag, " done"}, 32'(seen), 32'd1);
    endtask

    task automatic wait_log(input string tag, input int n, input int bound);
        bit seen = 1'b0;
        for (int k = 0; k < bound && !seen; k++) begin
            @(negedge clk);
            seen = (bus_log.size() >= n);
        end
        check({tag, " bus activity"}, 32'(seen), 32'd1);
    endtask

    task automatic check_log(input string tag, input int base);
        check({tag, " cycles"}, 32'(bus_log.size() - base), 32'(exp_log.size()));
        for (int i = 0; i < exp_log.size(); i++)
            check($sformatf("%s cycle%0d", tag, i),
                  (base + i < bus_log.size()) ? 32'(bus_log[base + i]) : 32'hFFFF,
                  32'(exp_log[i]));
    endtask

    initial begin
        logic [7:0] rd;
        int base, we0, re0, ce0, dn0;
        bit seen;

        // Reset values
        @(negedge clk);
        check("reset pins", 32'(pins()), 32'b1001_1000);
        check("reset io_write", 32'(io_write), 32'h00);
        check("reset status", 32'(status), 32'h00);
        check("reset host_rdata", 32'(host_rdata), 32'h00);
        @(negedge clk);
        rst = 1'b0;

        // Host latch: load, hold, clear
        host_write(12'h010, 8'hA5);
        host_read(12'h010, rd);
        check("host read", 32'(rd), 32'hA5);
        @(negedge clk);
        check("host latch hold", 32'(host_rdata), 32'hA5);
        host_rd_clr = 1'b1;
        @(negedge clk);
        host_rd_clr = 1'b0;
        check("host latch clear", 32'(host_rdata), 32'h00);

        // Read page: data must not be fetched before rb rises
        load_rec(8'h52, 40'h00_00_01_00_00, 16'h0004);
        rd_data[(re_falls + 0) % 16] = 8'h11;
        rd_data[(re_falls + 1) % 16] = 8'h22;
        rd_data[(re_falls + 2) % 16] = 8'h33;
        rd_data[(re_falls + 3) % 16] = 8'h44;
        rb = 1'b0;
        base = bus_log.size();
        re0 = re_falls;
        pulse_start();
        check("R busy", 32'(busy), 32'd1);
        wait_log("R", base + 7, 300);
        repeat (20) @(negedge clk);
        check("R reads before rb", 32'(re_falls - re0), 32'd0);
        rb = 1'b1;
        wait_done("R", 300);
        check("R status", 32'(status), 32'h00);
        check("R read count", 32'(re_falls - re0), 32'd4);
        exp_log = {cmd_e(8'h00), adr_e(8'h00), adr_e(8'h00), adr_e(8'h01),
                   adr_e(8'h00), adr_e(8'h00), cmd_e(8'h30)};
        check_log("R", base);
        host_read(12'h008, rd); check("R RAM[8]", 32'(rd), 32'h11);
        host_read(12'h009, rd); check("R RAM[9]", 32'(rd), 32'h22);
        host_read(12'h00A, rd); check("R RAM[10]", 32'(rd), 32'h33);
        host_read(12'h00B, rd); check("R RAM[11]", 32'(rd), 32'h44);

        // Program two bytes; a start pulse mid-operation is ignored
        load_rec(8'h57, 40'h00_00_02_00_00, 16'h0002);
        host_write(12'h008, 8'hDE);
        host_write(12'h009, 8'hAD);
        rd_data[re_falls % 16] = 8'hE0;
        base = bus_log.size();
        pulse_start();
        wait_log("W", base + 3, 300);
        pulse_start();
        wait_done("W", 400);
        check("W status", 32'(status), 32'hE0);
        exp_log = {cmd_e(8'h80), adr_e(8'h00), adr_e(8'h00), adr_e(8'h02),
                   adr_e(8'h00), adr_e(8'h00), dat_e(8'hDE), dat_e(8'hAD),
                   cmd_e(8'h10), cmd_e(8'h70)};
        check_log("W", base);

        // Erase with rb stuck low: times out
        load_rec(8'h45, 40'h00_00_05_06_07, 16'h0000);
        rb = 1'b0;
        base = bus_log.size();
        re0 = re_falls;
        pulse_start();
        wait_done("E", 400);
        check("E status", 32'(status), 32'hFE);
        check("E reads", 32'(re_falls - re0), 32'd0);
        exp_log = {cmd_e(8'h60), adr_e(8'h05), adr_e(8'h06), adr_e(8'h07), cmd_e(8'hD0)};
        check_log("E", base);
        @(negedge clk);
        check("E ce_n after done", 32'(ce_n), 32'd1);
        check("E busy after done", 32'(busy), 32'd0);
        rb = 1'b1;

        // Unknown opcode: no bus activity, second start ignored
        load_rec(8'h00, 40'h00_00_00_00_00, 16'h0004);
        we0 = we_falls; re0 = re_falls; ce0 = ce_low; dn0 = done_cnt;
        pulse_start();
        repeat (2) @(negedge clk);
        check("X busy", 32'(busy), 32'd1);
        pulse_start();
        wait_done("X", 100);
        check("X status", 32'(status), 32'hFF);
        repeat (12) @(negedge clk);
        check("X busy after", 32'(busy), 32'd0);
        check("X done pulses", 32'(done_cnt - dn0), 32'd1);
        check("X we_n toggles", 32'(we_falls - we0), 32'd0);
        check("X re_n toggles", 32'(re_falls - re0), 32'd0);
        check("X ce_n low", 32'(ce_low - ce0), 32'd0);

        // Reset in the middle of a program operation
        load_rec(8'h57, 40'h00_00_02_00_00, 16'h0002);
        rb = 1'b0;
        host_read(12'h010, rd);
        check("RST latch preload", 32'(rd), 32'hA5);
        pulse_start();
        seen = 1'b0;
        for (int n = 0; n < 200 && !seen; n++) begin
            @(negedge clk);
            seen = !we_n;
        end
        check("RST bus active", 32'(seen), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("RST pins", 32'(pins()), 32'b1001_1000);
        check("RST io_write", 32'(io_write), 32'h00);
        check("RST host_rdata", 32'(host_rdata), 32'h00);
        @(negedge clk);
        rst = 1'b0;
        rb = 1'b1;
        repeat (3) @(negedge clk);
        check("RST stays idle", 32'(pins()), 32'b1001_1000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
